// File: rtl/ins_sequencer.sv
// ins_sequencer: fetch/decode/execute timing controller for the 4-bit-opcode model computer.
// Strobes are decoded from the registered state; only pc_ld also looks at op/flag_g in EXEC.
module ins_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic             flag_g,
    input  logic             io_ack,
    output logic             mem_rd,
    output logic             ir_ld,
    output logic             opr_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             dec_en,
    output logic             exec_en,
    output logic             io_req,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, DECODE, OPFETCH, IOWAIT, EXEC, HALT} state_e;
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_e           state_q, state_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lat_last;
    assign lat_last = lat_q == LW'(MEM_LAT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        lat_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH: begin
                lat_d   = lat_last ? '0 : lat_q + 1'b1;
                state_d = lat_last ? LOAD : FETCH;
            end
            LOAD:    state_d = DECODE;
            DECODE:  state_d = (op == 4'b1010 || op == 4'b1011 || op == 4'b1110) ? OPFETCH :
                               (op == 4'b1100 || op == 4'b1101) ? IOWAIT :
                               (op == 4'b1111) ? HALT : EXEC;
            OPFETCH: begin
                lat_d   = lat_last ? '0 : lat_q + 1'b1;
                state_d = lat_last ? EXEC : OPFETCH;
            end
            IOWAIT:  state_d = io_ack ? EXEC : IOWAIT;
            EXEC: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = step ? IDLE : FETCH;
            end
            default: state_d = HALT;
        endcase
    end
    assign mem_rd    = state_q == FETCH || state_q == OPFETCH;
    assign ir_ld     = state_q == LOAD;
    assign opr_ld    = state_q == OPFETCH && lat_last;
    assign pc_inc    = ir_ld || opr_ld;
    assign pc_ld     = state_q == EXEC && (op == 4'b1010 || (op == 4'b1011 && flag_g));
    assign dec_en    = state_q == DECODE || state_q == OPFETCH || state_q == IOWAIT || state_q == EXEC;
    assign exec_en   = state_q == EXEC;
    assign io_req    = state_q == IOWAIT;
    assign busy      = state_q != IDLE && state_q != HALT;
    assign halted    = state_q == HALT;
    assign state     = state_q;
    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_ins_sequencer.sv
// tb_ins_sequencer: per-instruction expected state traces built from the cycle-count rules,
// with strobes and the retired count compared every cycle.
module tb_ins_sequencer;
    localparam int L  = 3;
    localparam int CW = 4;
    logic clk = 0, rst_n = 0, start = 0, step = 0, flag_g = 0, io_ack = 0;
    logic [3:0] op = 0;
    logic mem_rd, ir_ld, opr_ld, pc_inc, pc_ld, dec_en, exec_en, io_req, busy, halted;
    logic [2:0] state;
    logic [CW-1:0] instr_cnt;
    int n_vec = 0, n_err = 0, exp_cnt = 0;

    ins_sequencer #(.MEM_LAT(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .op(op), .flag_g(flag_g),
        .io_ack(io_ack), .mem_rd(mem_rd), .ir_ld(ir_ld), .opr_ld(opr_ld), .pc_inc(pc_inc),
        .pc_ld(pc_ld), .dec_en(dec_en), .exec_en(exec_en), .io_req(io_req), .busy(busy),
        .halted(halted), .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Caller leaves the DUT where the next edge enters FETCH (IDLE with start, or EXEC without step).
    task automatic run_instr(input logic [3:0] o, input logic f, input int w, input logic stp);
        int q[$];
        logic last;
        logic [9:0] exp_o, got_o;
        repeat (L) q.push_back(1);
        q.push_back(2);
        q.push_back(3);
        if (o == 4'b1010 || o == 4'b1011 || o == 4'b1110) repeat (L) q.push_back(4);
        else if (o == 4'b1100 || o == 4'b1101) repeat (w + 1) q.push_back(5);
        q.push_back(o == 4'b1111 ? 7 : 6);
        start = 1; op = o; flag_g = f;
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk); #1;
            start = 0;
            last = q[k] == 4 && (k + 1 >= q.size() || q[k+1] != 4);
            exp_o = {q[k] == 1 || q[k] == 4, q[k] == 2, last, q[k] == 2 || last,
                     q[k] == 6 && (o == 4'b1010 || (o == 4'b1011 && f)),
                     q[k] >= 3 && q[k] <= 6, q[k] == 6, q[k] == 5, q[k] != 7, q[k] == 7};
            got_o = {mem_rd, ir_ld, opr_ld, pc_inc, pc_ld, dec_en, exec_en, io_req, busy, halted};
            n_vec++;
            if (state !== 3'(q[k])) begin
                $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", o, k, state, q[k]); n_err++;
            end
            n_vec++;
            if (got_o !== exp_o) begin
                $display("FAIL strobes op=%b cyc=%0d got=%b exp=%b", o, k, got_o, exp_o); n_err++;
            end
            n_vec++;
            if (instr_cnt !== CW'(exp_cnt % (1 << CW))) begin
                $display("FAIL instr_cnt op=%b cyc=%0d got=%0d exp=%0d", o, k, instr_cnt, exp_cnt % (1 << CW)); n_err++;
            end
            io_ack = q[k] == 5 ? (k + 1 < q.size() && q[k+1] == 6) : 1'($urandom % 2);
            if (q[k] == 6) begin
                step = stp;
                exp_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({state, instr_cnt, mem_rd, ir_ld, opr_ld, pc_inc, pc_ld, dec_en, exec_en, io_req, busy, halted} !== '0) begin
            $display("FAIL reset state=%0d cnt=%0d busy=%b", state, instr_cnt, busy); n_err++;
        end
        rst_n = 1; exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL idle_no_start state=%0d busy=%b exp state=0 busy=0", state, busy); n_err++;
        end
    endtask

    task automatic test_single;
        run_instr(4'b0100, 0, 0, 0);
    endtask

    task automatic test_jg;
        run_instr(4'b1011, 0, 0, 0);
        run_instr(4'b1011, 1, 0, 0);
        run_instr(4'b1010, 0, 0, 0);
        run_instr(4'b1110, 1, 0, 0);
    endtask

    task automatic test_io;
        run_instr(4'b1100, 0, 4, 0);
        run_instr(4'b1101, 0, 0, 0);
    endtask

    task automatic test_step;
        run_instr(4'b1000, 0, 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
            n_vec++;
            if (state !== 3'd0 || busy !== 1'b0) begin
                $display("FAIL step_idle state=%0d busy=%b exp state=0 busy=0", state, busy); n_err++;
            end
        end
        run_instr(4'b0010, 0, 0, 0);
    endtask

    task automatic test_wrap;
        repeat (16) run_instr(4'b0000, 0, 0, 0);
    endtask

    task automatic test_random;
        repeat (40) run_instr(4'($urandom_range(0, 14)), 1'($urandom % 2), $urandom_range(0, 5), 0);
    endtask

    task automatic test_halt;
        logic [CW-1:0] c;
        run_instr(4'b1111, 0, 0, 0);
        c = CW'(exp_cnt % (1 << CW));
        repeat (6) begin
            start = 1'($urandom % 2);
            @(posedge clk); #1;
            n_vec++;
            if (state !== 3'd7 || halted !== 1'b1 || busy !== 1'b0 || instr_cnt !== c) begin
                $display("FAIL halt_hold state=%0d halted=%b cnt=%0d exp state=7 halted=1 cnt=%0d", state, halted, instr_cnt, c); n_err++;
            end
        end
        start = 0;
    endtask

    task automatic test_async_reset;
        int t;
        rst_n = 0; #1;
        rst_n = 1; exp_cnt = 0;
        @(posedge clk); #1;
        run_instr(4'b0000, 0, 0, 0);
        op = 4'b1010;
        t = 0;
        while (state !== 3'd4 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_vec++;
        if (state !== 3'd4) begin
            $display("FAIL opfetch_timeout state=%0d exp=4", state); n_err++;
        end
        @(posedge clk); #2;
        rst_n = 0; #1;
        n_vec++;
        if ({state, instr_cnt, mem_rd, ir_ld, opr_ld, pc_inc, pc_ld, dec_en, exec_en, io_req, busy, halted} !== '0) begin
            $display("FAIL async_reset state=%0d cnt=%0d mem_rd=%b dec_en=%b exp all 0", state, instr_cnt, mem_rd, dec_en); n_err++;
        end
        #4 rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_single;
        test_jg;
        test_io;
        test_step;
        test_wrap;
        test_random;
        test_halt;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
